// File: rtl/isp_pkg.sv
// Shared ISP definitions: frame-gate state encoding and write-FIFO constants.
package isp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    WAIT_DE,
    LINE,
    PAD,
    DONE,
    DROP
  } frame_gate_state_t;

  localparam logic [7:0] FIFO_ALPHA = 8'hFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/frame_gate_edge.sv
// Registers ISP vsync/data-enable and derives start/rise/fall strobes against the
// current input so that downstream data keeps a single cycle of latency.
module frame_gate_edge #(
  parameter bit VS_POL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic in_vs,
  input  logic in_de,
  output logic vs_act,
  output logic vs_start,
  output logic de_rise,
  output logic de_fall
);

  logic vs_act_q_reg;
  logic de_q_reg;

  assign vs_act = (in_vs == VS_POL);

  // Previous vsync resets to "active" so leaving reset during vsync is not taken as a frame start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vs_act_q_reg <= 1'b1;
      de_q_reg     <= 1'b0;
    end else begin
      vs_act_q_reg <= vs_act;
      de_q_reg     <= in_de;
    end
  end

  assign vs_start = vs_act & ~vs_act_q_reg;
  assign de_rise  = in_de & ~de_q_reg;
  assign de_fall  = ~in_de & de_q_reg;

endmodule

// File: rtl/isp_frame_gate.sv
// Conditions ISP frames into exactly H_PIXELS x V_PIXELS packed words for the DDR write port.
// Define FRAME_GATE_STATS_EN to build the short/long line and written-frame counters.
module isp_frame_gate
  import isp_pkg::*;
#(
  parameter int          H_PIXELS  = 1920,
  parameter int          V_PIXELS  = 1080,
  parameter bit          VS_POL    = 1'b1,
  parameter int          FRAME_DIV = 1,
  parameter logic [23:0] PAD_RGB   = 24'h000000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        in_vs,
  input  logic        in_de,
  input  logic [7:0]  in_r,
  input  logic [7:0]  in_g,
  input  logic [7:0]  in_b,
  output logic        wr_load,
  output logic        wrfifo_wren,
  output logic [31:0] wrfifo_din,
  output logic        frame_active,
  output logic        frame_err,
  output logic [15:0] short_lines,
  output logic [15:0] long_lines,
  output logic [15:0] frames_written
);

  localparam int PW = $clog2(H_PIXELS + 1);
  localparam int LW = $clog2(V_PIXELS + 1);
  localparam logic [PW-1:0] H_MAX    = PW'(H_PIXELS);
  localparam logic [PW-1:0] H_LAST   = PW'(H_PIXELS - 1);
  localparam logic [LW-1:0] L_LAST   = LW'(V_PIXELS - 1);
  localparam logic [3:0]    DIV_LAST = 4'(FRAME_DIV - 1);
  localparam logic [31:0]   PAD_WORD = {PAD_RGB, FIFO_ALPHA};

  frame_gate_state_t state_reg;
  logic [PW-1:0] pix_cnt_reg;
  logic [LW-1:0] line_cnt_reg;
  logic [3:0]    skip_cnt_reg;
  logic          line_long_reg;
  logic          frame_bad_reg;
  logic          wr_load_reg;
  logic          wren_reg;
  logic [31:0]   din_reg;
  logic          frame_active_reg;
  logic          frame_err_reg;

  logic vs_act, vs_start, de_rise, de_fall;
  logic pix_full, pad_last, last_line, short_hit, long_hit;
  logic [31:0] pix_word;

  frame_gate_edge #(.VS_POL(VS_POL)) u_edge (
    .clk      (clk),
    .rstn     (rstn),
    .in_vs    (in_vs),
    .in_de    (in_de),
    .vs_act   (vs_act),
    .vs_start (vs_start),
    .de_rise  (de_rise),
    .de_fall  (de_fall)
  );

  assign pix_full  = (pix_cnt_reg == H_MAX);
  assign pad_last  = (pix_cnt_reg == H_LAST);
  assign last_line = (line_cnt_reg == L_LAST);
  assign pix_word  = {in_r, in_g, in_b, FIFO_ALPHA};
  assign short_hit = (state_reg == LINE) && !vs_start && de_fall && !pix_full;
  assign long_hit  = (state_reg == LINE) && !vs_start && in_de && pix_full && !line_long_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg        <= IDLE;
      pix_cnt_reg      <= '0;
      line_cnt_reg     <= '0;
      skip_cnt_reg     <= '0;
      line_long_reg    <= 1'b0;
      frame_bad_reg    <= 1'b0;
      wr_load_reg      <= 1'b0;
      wren_reg         <= 1'b0;
      din_reg          <= PAD_WORD;
      frame_active_reg <= 1'b0;
      frame_err_reg    <= 1'b0;
    end else begin
      wr_load_reg   <= 1'b0;
      wren_reg      <= 1'b0;
      frame_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (vs_start) state_reg <= SYNC;
        end
        SYNC: begin
          pix_cnt_reg   <= '0;
          line_cnt_reg  <= '0;
          line_long_reg <= 1'b0;
          frame_bad_reg <= 1'b0;
          skip_cnt_reg  <= (skip_cnt_reg >= DIV_LAST) ? 4'd0 : skip_cnt_reg + 4'd1;
          if (enable && skip_cnt_reg == 4'd0) begin
            wr_load_reg      <= 1'b1;
            frame_active_reg <= 1'b1;
            state_reg        <= WAIT_DE;
          end else begin
            state_reg <= DROP;
          end
        end
        WAIT_DE: begin
          if (vs_start) begin
            frame_err_reg    <= 1'b1;
            frame_active_reg <= 1'b0;
            state_reg        <= SYNC;
          end else if (de_rise && !vs_act) begin
            wren_reg      <= 1'b1;
            din_reg       <= pix_word;
            pix_cnt_reg   <= PW'(1);
            line_long_reg <= 1'b0;
            state_reg     <= LINE;
          end
        end
        LINE: begin
          if (vs_start) begin
            frame_err_reg    <= 1'b1;
            frame_active_reg <= 1'b0;
            state_reg        <= SYNC;
          end else if (in_de) begin
            if (!pix_full) begin
              wren_reg    <= 1'b1;
              din_reg     <= pix_word;
              pix_cnt_reg <= pix_cnt_reg + 1'b1;
            end else if (long_hit) begin
              line_long_reg <= 1'b1;
              frame_bad_reg <= 1'b1;
            end
          end else if (short_hit) begin
            // First pad word goes out on the cycle right after the falling edge.
            wren_reg      <= 1'b1;
            din_reg       <= PAD_WORD;
            pix_cnt_reg   <= pix_cnt_reg + 1'b1;
            frame_bad_reg <= 1'b1;
            if (pad_last) begin
              pix_cnt_reg  <= '0;
              line_cnt_reg <= line_cnt_reg + 1'b1;
              state_reg    <= last_line ? DONE : WAIT_DE;
            end else begin
              state_reg <= PAD;
            end
          end else begin
            pix_cnt_reg  <= '0;
            line_cnt_reg <= line_cnt_reg + 1'b1;
            state_reg    <= last_line ? DONE : WAIT_DE;
          end
        end
        PAD: begin
          if (vs_start) begin
            frame_err_reg    <= 1'b1;
            frame_active_reg <= 1'b0;
            state_reg        <= SYNC;
          end else if (de_rise) begin
            // Next line arrived early: close this one and take the new pixel immediately.
            line_cnt_reg <= line_cnt_reg + 1'b1;
            if (last_line) begin
              pix_cnt_reg <= '0;
              state_reg   <= DONE;
            end else begin
              wren_reg      <= 1'b1;
              din_reg       <= pix_word;
              pix_cnt_reg   <= PW'(1);
              line_long_reg <= 1'b0;
              state_reg     <= LINE;
            end
          end else begin
            wren_reg    <= 1'b1;
            din_reg     <= PAD_WORD;
            pix_cnt_reg <= pix_cnt_reg + 1'b1;
            if (pad_last) begin
              pix_cnt_reg  <= '0;
              line_cnt_reg <= line_cnt_reg + 1'b1;
              state_reg    <= last_line ? DONE : WAIT_DE;
            end
          end
        end
        DONE: begin
          frame_active_reg <= 1'b0;
          if (vs_start) begin
            frame_err_reg <= frame_bad_reg;
            state_reg     <= SYNC;
          end else if (in_de) begin
            frame_bad_reg <= 1'b1;
          end
        end
        DROP: begin
          if (vs_start) state_reg <= SYNC;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign wr_load      = wr_load_reg;
  assign wrfifo_wren  = wren_reg;
  assign wrfifo_din   = din_reg;
  assign frame_active = frame_active_reg;
  assign frame_err    = frame_err_reg;

`ifdef FRAME_GATE_STATS_EN
  logic [2:0] stat_hit;
  assign stat_hit = {wr_load_reg, long_hit, short_hit};

  for (genvar gi = 0; gi < 3; gi++) begin : g_stat
    logic [15:0] cnt_reg;
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        cnt_reg <= '0;
      end else if (stat_hit[gi]) begin
        cnt_reg <= sat_inc16(cnt_reg);
      end
    end
  end

  assign short_lines    = g_stat[0].cnt_reg;
  assign long_lines     = g_stat[1].cnt_reg;
  assign frames_written = g_stat[2].cnt_reg;
`else
  assign short_lines    = '0;
  assign long_lines     = '0;
  assign frames_written = '0;
`endif

endmodule

// File: tb/tb_isp_frame_gate.sv
// Scoreboard bench for isp_frame_gate: 8x4 frames, expected words queued at drive time.
module tb_isp_frame_gate;

  localparam int          H = 8;
  localparam int          V = 4;
  localparam logic [23:0] PAD = 24'h5A3C96;
  localparam logic [31:0] PAD_WORD = {PAD, 8'hFF};
`ifdef FRAME_GATE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic enable = 1'b1;
  logic in_vs = 1'b0;
  logic in_de = 1'b0;
  logic [7:0] in_r = '0, in_g = '0, in_b = '0;

  logic        wr_load, wrfifo_wren, frame_active, frame_err;
  logic [31:0] wrfifo_din;
  logic [15:0] short_lines, long_lines, frames_written;
  logic        wr_load2, wren2, fa2, ferr2;
  logic [31:0] din2;
  logic [15:0] sl2, ll2, fw2;

  always #5 clk = ~clk;

  isp_frame_gate #(.H_PIXELS(H), .V_PIXELS(V), .VS_POL(1'b1), .FRAME_DIV(1), .PAD_RGB(PAD)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .in_vs(in_vs), .in_de(in_de),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .wr_load(wr_load), .wrfifo_wren(wrfifo_wren), .wrfifo_din(wrfifo_din),
    .frame_active(frame_active), .frame_err(frame_err),
    .short_lines(short_lines), .long_lines(long_lines), .frames_written(frames_written)
  );

  isp_frame_gate #(.H_PIXELS(H), .V_PIXELS(V), .VS_POL(1'b1), .FRAME_DIV(3), .PAD_RGB(PAD)) dut_div (
    .clk(clk), .rstn(rstn), .enable(enable), .in_vs(in_vs), .in_de(in_de),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .wr_load(wr_load2), .wrfifo_wren(wren2), .wrfifo_din(din2),
    .frame_active(fa2), .frame_err(ferr2),
    .short_lines(sl2), .long_lines(ll2), .frames_written(fw2)
  );

  int n_total = 0;
  int n_bad = 0;
  int unsigned cyc = 0;
  int n_wr = 0, n_ld = 0, n_err = 0, n_ld2 = 0;
  int b_wr, b_ld, b_err, b_ld2;
  bit div_phase = 1'b0;
  int cur_frame = 0;

  logic [31:0] data_q[$];
  logic [31:0] dcyc_q[$];
  logic [31:0] ld_q[$];

  int ln_len[8];
  int ln_gap[8];
  int n_lines;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wrfifo_wren) begin
      n_wr++;
      chk("fa_on_write", frame_active, 1);
      if (data_q.size() == 0) begin
        chk("write_extra", 1, 0);
      end else begin
        chk("write_data", wrfifo_din, data_q.pop_front());
        chk("write_cycle", cyc, dcyc_q.pop_front());
      end
    end
    if (wr_load) begin
      n_ld++;
      if (ld_q.size() == 0) chk("load_extra", 1, 0);
      else chk("load_cycle", cyc, ld_q.pop_front());
    end
    if (frame_err) n_err++;
    if (wr_load2) begin
      n_ld2++;
      if (div_phase) chk("div_frame_mod3", cur_frame % 3, 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic vsync(input bit push_ld);
    for (int i = 0; i < 3; i++) begin
      step();
      in_vs = 1'b1;
      in_de = 1'b0;
      if (i == 0 && push_ld) ld_q.push_back(cyc + 2);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      in_vs = 1'b0;
    end
  endtask

  // Written frames push one expected word per pixel/pad, stamped with its output cycle.
  task automatic send_frame(input bit exp_wr, input int rst_at);
    logic [23:0] rgb;
    int done_l;
    int npad;
    vsync(exp_wr);
    done_l = 0;
    for (int l = 0; l < n_lines; l++) begin
      if (l == rst_at) rstn = 1'b1;
      for (int p = 0; p < ln_len[l]; p++) begin
        step();
        in_de = 1'b1;
        rgb = 24'($urandom);
        {in_r, in_g, in_b} = rgb;
        if (exp_wr && done_l < V && p < H) begin
          data_q.push_back({rgb, 8'hFF});
          dcyc_q.push_back(cyc + 1);
        end
      end
      npad = 0;
      if (done_l < V && ln_len[l] < H) npad = (H - ln_len[l] < ln_gap[l]) ? H - ln_len[l] : ln_gap[l];
      for (int g = 0; g < ln_gap[l]; g++) begin
        step();
        in_de = 1'b0;
        if (exp_wr && g < npad) begin
          data_q.push_back(PAD_WORD);
          dcyc_q.push_back(cyc + 1);
        end
      end
      done_l++;
    end
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic set_lines(input int n);
    n_lines = n;
    for (int i = 0; i < 8; i++) begin
      ln_len[i] = H;
      ln_gap[i] = 4;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    in_vs = 1'b0;
    in_de = 1'b0;
    for (int i = 0; i < 3; i++) step();
    rstn = 1'b1;
    for (int i = 0; i < 2; i++) step();
  endtask

  task automatic snap();
    b_wr = n_wr;
    b_ld = n_ld;
    b_err = n_err;
    b_ld2 = n_ld2;
  endtask

  // A disabled vsync closes the last frame (frame_err decision) without starting another.
  task automatic end_test(input string tag, input int ew, input int eld, input int eerr,
                          input int esh, input int elg, input int efw);
    enable = 1'b0;
    vsync(1'b0);
    for (int i = 0; i < 4; i++) step();
    enable = 1'b1;
    chk({tag, "_writes"}, n_wr - b_wr, ew);
    chk({tag, "_loads"}, n_ld - b_ld, eld);
    chk({tag, "_frame_err"}, n_err - b_err, eerr);
    chk({tag, "_data_left"}, data_q.size(), 0);
    chk({tag, "_load_left"}, ld_q.size(), 0);
    chk({tag, "_short_lines"}, short_lines, STATS ? esh : 0);
    chk({tag, "_long_lines"}, long_lines, STATS ? elg : 0);
    chk({tag, "_frames_written"}, frames_written, STATS ? efw : 0);
    $display("test %s: writes=%0d loads=%0d errs=%0d", tag, n_wr - b_wr, n_ld - b_ld, n_err - b_err);
  endtask

  initial begin
    // Reset state
    for (int i = 0; i < 2; i++) step();
    chk("rst_wr_load", wr_load, 0);
    chk("rst_wren", wrfifo_wren, 0);
    chk("rst_din", wrfifo_din, PAD_WORD);
    chk("rst_frame_active", frame_active, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_stats", {short_lines, long_lines, frames_written}, 0);

    // Nominal: three full frames
    do_reset();
    snap();
    set_lines(4);
    for (int f = 0; f < 3; f++) send_frame(1'b1, -1);
    end_test("nominal", 96, 3, 0, 0, 0, 3);

    // Short line 2: 5 pixels, 6 idle cycles
    do_reset();
    snap();
    set_lines(4);
    ln_len[2] = 5;
    ln_gap[2] = 6;
    send_frame(1'b1, -1);
    end_test("short", 32, 1, 1, 1, 0, 1);

    // Long line 1 and 6-line frame
    do_reset();
    snap();
    set_lines(6);
    ln_len[1] = 11;
    send_frame(1'b1, -1);
    end_test("long", 32, 1, 1, 0, 1, 1);

    // Reset released in the middle of a frame
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) step();
    snap();
    set_lines(4);
    send_frame(1'b0, 1);
    send_frame(1'b1, -1);
    end_test("midstart", 32, 1, 0, 0, 0, 1);

    // Decimated instance over six frames
    do_reset();
    snap();
    set_lines(4);
    div_phase = 1'b1;
    for (int f = 0; f < 6; f++) begin
      cur_frame = f;
      send_frame(1'b1, -1);
    end
    div_phase = 1'b0;
    chk("div_loads", n_ld2 - b_ld2, 2);
    chk("div_frames_written", fw2, STATS ? 2 : 0);
    end_test("div", 192, 6, 0, 0, 0, 6);

    // Pad collision: 2-pixel line, next line rises 2 cycles after the fall
    do_reset();
    snap();
    set_lines(4);
    ln_len[1] = 2;
    ln_gap[1] = 2;
    send_frame(1'b1, -1);
    end_test("collision", 28, 1, 1, 1, 0, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
